uart_tx_stream: RTL and testbench

UART_TX_STREAM -- requirements
Module: uart_tx_stream

---
 rtl/uart_tx_stream.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit; PARITY_ODD selects its sense.
module uart_tx_stream #(
    parameter int CLK_DIV    = 400,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA,
    input  logic              VALID,
    output logic              READY,
    output logic              TX,
    output logic              BUSY,
    output logic              DONE
);

    localparam int BDW = $clog2(CLK_DIV);
    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [BDW-1:0] BAUD_MAX  = BDW'(CLK_DIV - 1);
    localparam logic [BDW-1:0] BAUD_ONE  = BDW'(1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("CLK_DIV out of range");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
        $error("DATA_W out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state, state_nxt;
    logic [BDW-1:0]    baud_cnt, baud_nxt;
    logic [BCW-1:0]    bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              tx_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_nxt;
`endif

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        tx_nxt    = 1'b1;
        done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            S_IDLE: begin
                if (READY && VALID) begin
                    state_nxt = S_START;
                    baud_nxt  = BAUD_MAX;
                    bit_nxt   = '0;
                    shreg_nxt = DATA;
                    tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = (^DATA) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (baud_cnt == '0) begin
                    state_nxt = S_DATA;
                    baud_nxt  = BAUD_MAX;
                    tx_nxt    = shreg[0];
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end
            S_DATA: begin
                tx_nxt = shreg[0];
                if (baud_cnt == '0) begin
                    baud_nxt = BAUD_MAX;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + BIT_ONE;
                        shreg_nxt = shreg >> 1;
                        tx_nxt    = shreg[1];
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_nxt = par_q;
                if (baud_cnt == '0) begin
                    state_nxt = S_STOP;
                    baud_nxt  = BAUD_MAX;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                // The final stop-bit cycle is spent in IDLE with READY high, so a
                // waiting frame starts on the very next edge with no gap.
                if (bit_cnt == STOP_LAST && baud_cnt == BAUD_ONE) begin
                    state_nxt = S_IDLE;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (baud_cnt == '0) begin
                    baud_nxt = BAUD_MAX;
                    bit_nxt  = bit_cnt + BIT_ONE;
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            TX       <= 1'b1;
            READY    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            TX       <= tx_nxt;
            READY    <= (state_nxt == S_IDLE);
            BUSY     <= (state_nxt != S_IDLE);
            DONE     <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CLK_DIV=4, DATA_W=8: framing, back-to-back, stop bits, parity, reset abort.
// Cycle k of a frame is the clock period following the (k-1)-th edge after the acceptance edge.
module tb_uart_tx_stream;

    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NF1 = (10 + P) * CD;
    localparam int NF2 = (11 + P) * CD;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] data = 8'h00;
    logic [2:0] valid = 3'b000;
    logic [2:0] ready, tx, busy, done;

    int checks = 0;
    int failures = 0;
    int sel = 0;
    logic tx_log [0:255];
    logic done_log [0:255];
    logic ready_log [0:255];
    logic busy_log [0:255];

    uart_tx_stream #(.CLK_DIV(CD), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .DATA(data), .VALID(valid[0]),
        .READY(ready[0]), .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0]));
    uart_tx_stream #(.CLK_DIV(CD), .DATA_W(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .DATA(data), .VALID(valid[1]),
        .READY(ready[1]), .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1]));
    uart_tx_stream #(.CLK_DIV(CD), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (
        .CLK(CLK), .RST(RST), .DATA(data), .VALID(valid[2]),
        .READY(ready[2]), .TX(tx[2]), .BUSY(busy[2]), .DONE(done[2]));

    always #5 CLK = ~CLK;

    // Expected line level in frame cycle k (1-based); anything past the payload is stop/idle high.
    function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int k);
        int bi;
        bi = (k - 1) / CD;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return d[bi-1];
        if (P == 1 && bi == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic start_frame(input int s, input logic [7:0] d);
        int n;
        n = 0;
        sel = s;
        while (ready[s] !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (ready[s] !== 1'b1) begin
            failures++;
            $display("FAIL start_wait dut=%0d ready=%b required=1", s, ready[s]);
        end
        data = d;
        valid[s] = 1'b1;
        @(posedge CLK);
    endtask

    task automatic capture(input int n, input int vdrop, input int dchg, input logic [7:0] dval);
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            tx_log[k]    = tx[sel];
            done_log[k]  = done[sel];
            ready_log[k] = ready[sel];
            busy_log[k]  = busy[sel];
            if (k == vdrop) valid[sel] = 1'b0;
            if (k == dchg) data = dval;
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (tx !== 3'b111) begin failures++; $display("FAIL rst_tx got=%b required=111", tx); end
        checks++;
        if (ready !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b required=000", ready); end
        checks++;
        if (busy !== 3'b000) begin failures++; $display("FAIL rst_busy got=%b required=000", busy); end
        checks++;
        if (done !== 3'b000) begin failures++; $display("FAIL rst_done got=%b required=000", done); end
        RST = 1'b0;
        #1;
        checks++;
        if (ready !== 3'b000) begin failures++; $display("FAIL rel_ready_pre got=%b required=000", ready); end
        @(negedge CLK);
        checks++;
        if (ready !== 3'b111) begin failures++; $display("FAIL rel_ready got=%b required=111", ready); end
        checks++;
        if (busy !== 3'b000) begin failures++; $display("FAIL rel_busy got=%b required=000", busy); end
    endtask

    task automatic test_a5;
        start_frame(0, 8'hA5);
        capture(NF1 + 1, 1, 0, 8'h00);
        for (int k = 1; k <= NF1 + 1; k++) begin
            checks++;
            if (tx_log[k] !== exp_bit(8'hA5, 1'b0, k)) begin
                failures++;
                $display("FAIL a5_tx cyc=%0d got=%b required=%b", k, tx_log[k], exp_bit(8'hA5, 1'b0, k));
            end
            checks++;
            if (done_log[k] !== (k == NF1)) begin
                failures++;
                $display("FAIL a5_done cyc=%0d got=%b required=%b", k, done_log[k], (k == NF1));
            end
        end
        checks++;
        if (ready_log[1] !== 1'b0 || busy_log[1] !== 1'b1) begin
            failures++;
            $display("FAIL a5_accept ready=%b busy=%b required ready=0 busy=1", ready_log[1], busy_log[1]);
        end
        checks++;
        if (ready_log[NF1] !== 1'b1 || busy_log[NF1] !== 1'b0) begin
            failures++;
            $display("FAIL a5_end ready=%b busy=%b required ready=1 busy=0", ready_log[NF1], busy_log[NF1]);
        end
        checks++;
        if (busy_log[NF1 - 1] !== 1'b1) begin
            failures++;
            $display("FAIL a5_busy_late got=%b required=1", busy_log[NF1 - 1]);
        end
    endtask

    task automatic test_back_to_back;
        start_frame(0, 8'h00);
        capture(2 * NF1 + 1, NF1 + 1, 1, 8'hFF);
        for (int k = 1; k <= 2 * NF1; k++) begin
            logic e;
            e = (k <= NF1) ? exp_bit(8'h00, 1'b0, k) : exp_bit(8'hFF, 1'b0, k - NF1);
            checks++;
            if (tx_log[k] !== e) begin
                failures++;
                $display("FAIL b2b_tx cyc=%0d got=%b required=%b", k, tx_log[k], e);
            end
            checks++;
            if (done_log[k] !== (k == NF1 || k == 2 * NF1)) begin
                failures++;
                $display("FAIL b2b_done cyc=%0d got=%b required=%b", k, done_log[k], (k == NF1 || k == 2 * NF1));
            end
        end
        checks++;
        if (tx_log[NF1 + 1] !== 1'b0 || ready_log[NF1 + 1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap tx=%b ready=%b required tx=0 ready=0", tx_log[NF1 + 1], ready_log[NF1 + 1]);
        end
        checks++;
        if (tx_log[2 * NF1 + 1] !== 1'b1 || ready_log[2 * NF1 + 1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle tx=%b ready=%b required tx=1 ready=1", tx_log[2 * NF1 + 1], ready_log[2 * NF1 + 1]);
        end
    endtask

    task automatic test_data_change;
        start_frame(0, 8'h96);
        capture(NF1 + 1, 1, 6, 8'h69);
        for (int k = 1; k <= NF1; k++) begin
            checks++;
            if (tx_log[k] !== exp_bit(8'h96, 1'b0, k)) begin
                failures++;
                $display("FAIL dchg_tx cyc=%0d got=%b required=%b", k, tx_log[k], exp_bit(8'h96, 1'b0, k));
            end
        end
    endtask

    task automatic test_stop2;
        start_frame(1, 8'h3C);
        capture(NF2 + 1, 1, 0, 8'h00);
        for (int k = 1; k <= NF2 + 1; k++) begin
            checks++;
            if (tx_log[k] !== exp_bit(8'h3C, 1'b0, k)) begin
                failures++;
                $display("FAIL stop2_tx cyc=%0d got=%b required=%b", k, tx_log[k], exp_bit(8'h3C, 1'b0, k));
            end
            checks++;
            if (done_log[k] !== (k == NF2)) begin
                failures++;
                $display("FAIL stop2_done cyc=%0d got=%b required=%b", k, done_log[k], (k == NF2));
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        start_frame(0, 8'h07);
        capture(NF1 + 1, 1, 0, 8'h00);
        for (int k = 9 * CD + 1; k <= 10 * CD; k++) begin
            checks++;
            if (tx_log[k] !== 1'b1) begin
                failures++;
                $display("FAIL par_even cyc=%0d got=%b required=1", k, tx_log[k]);
            end
        end
        checks++;
        if (done_log[44] !== 1'b1 || done_log[43] !== 1'b0) begin
            failures++;
            $display("FAIL par_len done43=%b done44=%b required 0,1", done_log[43], done_log[44]);
        end
        start_frame(2, 8'h07);
        capture(NF1 + 1, 1, 0, 8'h00);
        for (int k = 9 * CD + 1; k <= 10 * CD; k++) begin
            checks++;
            if (tx_log[k] !== 1'b0) begin
                failures++;
                $display("FAIL par_odd cyc=%0d got=%b required=0", k, tx_log[k]);
            end
        end
        checks++;
        if (done_log[44] !== 1'b1) begin
            failures++;
            $display("FAIL par_odd_len done44=%b required=1", done_log[44]);
        end
    endtask
`endif

    task automatic test_reset_mid;
        // 0x37 has bit 3 = 0, so the line is low when reset hits
        start_frame(0, 8'h37);
        capture(18, 1, 0, 8'h00);
        checks++;
        if (tx[0] !== 1'b0) begin failures++; $display("FAIL mid_pre_tx got=%b required=0", tx[0]); end
        RST = 1'b1;
        #1;
        checks++;
        if (tx[0] !== 1'b1) begin failures++; $display("FAIL mid_tx got=%b required=1", tx[0]); end
        checks++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_flags ready=%b busy=%b required 0,0", ready[0], busy[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (done[0] !== 1'b0) begin failures++; $display("FAIL mid_done got=%b required=0", done[0]); end
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_release ready=%b done=%b required 1,0", ready[0], done[0]);
        end
        start_frame(0, 8'hC3);
        capture(NF1 + 1, 1, 0, 8'h00);
        for (int k = 1; k <= NF1 + 1; k++) begin
            checks++;
            if (tx_log[k] !== exp_bit(8'hC3, 1'b0, k)) begin
                failures++;
                $display("FAIL mid_next_tx cyc=%0d got=%b required=%b", k, tx_log[k], exp_bit(8'hC3, 1'b0, k));
            end
            checks++;
            if (done_log[k] !== (k == NF1)) begin
                failures++;
                $display("FAIL mid_next_done cyc=%0d got=%b required=%b", k, done_log[k], (k == NF1));
            end
        end
    endtask

    initial begin
        test_reset;
        test_a5;
        test_back_to_back;
        test_data_change;
        test_stop2;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
